// File: rtl/memcmddecode.sv
// DRAM command pin decoder: turns sampled pins into registered command strobes,
// tracks CKE and low-power mode, and holds column commands until the timing FSM takes them.
module memcmddecode #(
  parameter int HOLD_MAX = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cke,
  input  logic       cs_n,
  input  logic       act_n,
  input  logic       ras_n,
  input  logic       cas_n,
  input  logic       we_n,
  input  logic       a10,
  input  logic       cfg_req,
  input  logic [4:0] stateout,
  output logic       ACT,
  output logic       BST,
  output logic       CFG,
  output logic       MRR,
  output logic       MRW,
  output logic       PR,
  output logic       PRA,
  output logic       REF,
  output logic       SRF,
  output logic       PD,
  output logic       PDX,
  output logic       DPD,
  output logic       DPDX,
  output logic       RD,
  output logic       RDA,
  output logic       WR,
  output logic       WRA,
  output logic       CKEH,
  output logic       CKEL,
  output logic       cmd_err,
  output logic [1:0] lpmode
);

  typedef enum logic [1:0] {LP_NONE = 2'd0, LP_PDN = 2'd1, LP_DPDN = 2'd2, LP_SREF = 2'd3} lp_t;
  typedef enum logic [1:0] {COL_RD = 2'd0, COL_RDA = 2'd1, COL_WR = 2'd2, COL_WRA = 2'd3} col_t;

  localparam logic [4:0] ST_IDLE = 5'h00, ST_ACTIVE = 5'h03, ST_PRE = 5'h0A, ST_READ = 5'h0B,
                         ST_READ_AP = 5'h0C, ST_WRITE = 5'h12, ST_WRITE_AP = 5'h13;
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  localparam int P_ACT = 0, P_BST = 1, P_CFG = 2, P_MRR = 3, P_MRW = 4, P_PR = 5, P_PRA = 6,
                 P_REF = 7, P_SRF = 8, P_PD = 9, P_PDX = 10, P_DPD = 11, P_DPDX = 12,
                 P_CKEH = 13, P_ERR = 14, NP = 15;

  logic          cke_q;
  lp_t           lp_reg, lp_next;
  logic          pend_valid_reg, pend_valid_next;
  col_t          pend_cmd_reg, pend_cmd_next;
  logic [7:0]    hold_reg, hold_next;
  logic [NP-1:0] pulse_reg, pulse_next;
  logic [4:0]    target;
  logic [2:0]    rcw;
  logic          in_idle, col_ok, normal, entry, wake;

  assign rcw     = {ras_n, cas_n, we_n};
  assign in_idle = (stateout == ST_IDLE);
  assign col_ok  = (stateout == ST_ACTIVE) || (stateout == ST_READ) || (stateout == ST_WRITE);
  assign normal  = cke_q && cke && !cs_n && (lp_reg == LP_NONE);
  assign entry   = cke_q && !cke && (lp_reg == LP_NONE);
  assign wake    = !cke_q && cke;

  always_comb begin
    pulse_next      = '0;
    lp_next         = lp_reg;
    pend_valid_next = pend_valid_reg;
    pend_cmd_next   = pend_cmd_reg;
    hold_next       = hold_reg;
    target          = ST_READ;
    case (pend_cmd_reg)
      COL_RD:  target = ST_READ;
      COL_RDA: target = ST_READ_AP;
      COL_WR:  target = ST_WRITE;
      default: target = ST_WRITE_AP;
    endcase

    pulse_next[P_CFG] = cfg_req;

    // Acceptance beats abort, abort beats timeout.
    if (pend_valid_reg) begin
      if (stateout == target) begin
        pend_valid_next = 1'b0;
      end else if (stateout == ST_PRE || in_idle) begin
        pend_valid_next   = 1'b0;
        pulse_next[P_ERR] = 1'b1;
      end else if (hold_reg == HOLD_LAST) begin
        pend_valid_next   = 1'b0;
        pulse_next[P_ERR] = 1'b1;
      end else if (hold_reg != 8'hFF) begin
        hold_next = hold_reg + 8'd1;
      end
    end

    if (normal) begin
      if (!act_n) begin
        if (in_idle) pulse_next[P_ACT] = 1'b1;
        else         pulse_next[P_ERR] = 1'b1;
      end else begin
        case (rcw)
          3'b000: if (in_idle) pulse_next[P_MRW] = 1'b1; else pulse_next[P_ERR] = 1'b1;
          3'b001: if (in_idle) pulse_next[P_REF] = 1'b1; else pulse_next[P_ERR] = 1'b1;
          3'b010: if (a10) pulse_next[P_PRA] = 1'b1; else pulse_next[P_PR] = 1'b1;
          3'b011: pulse_next[P_BST] = 1'b1;
          3'b100, 3'b101: begin
            if (col_ok) begin
              pend_valid_next = 1'b1;
              hold_next       = 8'd0;
              if (rcw[0]) pend_cmd_next = a10 ? COL_RDA : COL_RD;
              else        pend_cmd_next = a10 ? COL_WRA : COL_WR;
            end else begin
              pulse_next[P_ERR] = 1'b1;
            end
          end
          3'b110: if (in_idle) pulse_next[P_MRR] = 1'b1; else pulse_next[P_ERR] = 1'b1;
          default: ;
        endcase
      end
    end

    if (entry) begin
      if (!cs_n && act_n && rcw == 3'b001) begin
        if (in_idle) begin
          pulse_next[P_SRF] = 1'b1;
          lp_next           = LP_SREF;
        end else begin
          pulse_next[P_ERR] = 1'b1;
        end
      end else if (!cs_n && act_n && rcw == 3'b110) begin
        if (in_idle) begin
          pulse_next[P_DPD] = 1'b1;
          lp_next           = LP_DPDN;
        end else begin
          pulse_next[P_ERR] = 1'b1;
        end
      end else begin
        pulse_next[P_PD] = 1'b1;
        lp_next          = LP_PDN;
      end
    end

    if (wake) begin
      pulse_next[P_CKEH] = 1'b1;
      pulse_next[P_PDX]  = (lp_reg == LP_PDN);
      pulse_next[P_DPDX] = (lp_reg == LP_DPDN);
      lp_next            = LP_NONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cke_q          <= 1'b0;
      lp_reg         <= LP_NONE;
      pend_valid_reg <= 1'b0;
      pend_cmd_reg   <= COL_RD;
      hold_reg       <= 8'd0;
      pulse_reg      <= '0;
    end else begin
      cke_q          <= cke;
      lp_reg         <= lp_next;
      pend_valid_reg <= pend_valid_next;
      pend_cmd_reg   <= pend_cmd_next;
      hold_reg       <= hold_next;
      pulse_reg      <= pulse_next;
    end
  end

  assign ACT     = pulse_reg[P_ACT];
  assign BST     = pulse_reg[P_BST];
  assign CFG     = pulse_reg[P_CFG];
  assign MRR     = pulse_reg[P_MRR];
  assign MRW     = pulse_reg[P_MRW];
  assign PR      = pulse_reg[P_PR];
  assign PRA     = pulse_reg[P_PRA];
  assign REF     = pulse_reg[P_REF];
  assign SRF     = pulse_reg[P_SRF];
  assign PD      = pulse_reg[P_PD];
  assign PDX     = pulse_reg[P_PDX];
  assign DPD     = pulse_reg[P_DPD];
  assign DPDX    = pulse_reg[P_DPDX];
  assign CKEH    = pulse_reg[P_CKEH];
  assign cmd_err = pulse_reg[P_ERR];
  assign CKEL    = !cke_q;
  assign lpmode  = lp_reg;
  assign RD      = pend_valid_reg && (pend_cmd_reg == COL_RD);
  assign RDA     = pend_valid_reg && (pend_cmd_reg == COL_RDA);
  assign WR      = pend_valid_reg && (pend_cmd_reg == COL_WR);
  assign WRA     = pend_valid_reg && (pend_cmd_reg == COL_WRA);

endmodule

// File: doc/memcmddecode.md
# memcmddecode

Command front end for the memory timing model. It samples the DRAM command pins (CKE, CS_n, ACT_n, RAS_n, CAS_n, WE_n, A10) every clock and turns them into the one-cycle or held command strobes that the bank timing state machine consumes (ACT, RD, WR, PR, PD, SRF, ...). It tracks CKE history and the low-power mode so entry and exit strobes are correct. It holds column commands until the timing FSM, observed through its `stateout` code, accepts them.

## Interface
Parameters:
- HOLD_MAX, 32: maximum cycles a column command is held pending before it is dropped with an error.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst  input  1  asynchronous, active-low reset.
- cke  input  1  clock enable pin.
- cs_n, act_n, ras_n, cas_n, we_n  input  1 each  command pins, active low.
- a10  input  1  auto-precharge / precharge-all bit.
- cfg_req  input  1  configuration request; forwarded as CFG.
- stateout  input  5  timing FSM state code: Idle=0x00, Activating=0x01, BankActive=0x03, Precharging=0x0A, Reading=0x0B, ReadingAPR=0x0C, Writing=0x12, WritingAPR=0x13.
- ACT, BST, CFG, MRR, MRW, PR, PRA, REF, SRF, PD, PDX, DPD, DPDX  output  1 each  one-cycle command strobes.
- RD, RDA, WR, WRA  output  1 each  held column strobes; at most one is high at a time.
- CKEH  output  1  one-cycle pulse on a CKE 0->1 transition.
- CKEL  output  1  level, high while registered CKE is low.
- cmd_err  output  1  one-cycle pulse on an illegal or dropped command.
- lpmode  output  2  low-power mode: 0 NONE, 1 PDN, 2 DPDN, 3 SREF.

## Operation
- Every output resets to 0, with one exception: CKEL resets to 1, because cke_q resets to 0. lpmode resets to NONE, the pending register is empty, and the hold counter is 0.
- cke_q holds the registered previous value of cke.
- A normal command is decoded when cke_q=1, cke=1, and cs_n=0:
  - act_n=0: ACT.
  - Otherwise {ras_n,cas_n,we_n} selects the command:
    - 000: MRW.
    - 001: REF.
    - 010: PRA if a10=1, else PR.
    - 011: BST.
    - 100: WRA if a10=1, else WR.
    - 101: RDA if a10=1, else RD.
    - 110: MRR.
    - 111: NOP, no output.
  - cs_n=1 is deselect and produces no output.
- Entry on CKE falling (cke_q=1, cke=0) in lpmode NONE:
  - cs_n=0, act_n=1, {ras_n,cas_n,we_n}=001: SRF; lpmode becomes SREF.
  - cs_n=0, act_n=1, {ras_n,cas_n,we_n}=110: DPD; lpmode becomes DPDN.
  - Anything else: PD; lpmode becomes PDN.
- Exit on CKE rising (cke_q=0, cke=1):
  - CKEH pulses.
  - PDN additionally pulses PDX; DPDN additionally pulses DPDX; SREF pulses only CKEH.
  - lpmode returns to NONE.
- Commands decoded while lpmode is not NONE are ignored; no cmd_err is raised.
- Legality checks, applied against stateout in the sampling cycle. An illegal command is suppressed and cmd_err pulses.
  - ACT, REF, MRW, MRR, SRF, DPD: only in Idle.
  - RD, RDA, WR, WRA: only in BankActive, Reading, or Writing.
  - PR, PRA, BST: always legal.
- Pending column register:
  - A legal column command loads the register and resets the hold counter to 0.
  - A new legal column command arriving while one is pending replaces it. The replacement does not raise cmd_err.
  - The pending strobe is driven high every cycle while pending.
  - The register clears when stateout equals the target state: Reading for RD, ReadingAPR for RDA, Writing for WR, WritingAPR for WRA.
  - Abort rule: if stateout is Precharging or Idle while a command is pending, the register clears and cmd_err pulses.
  - Timeout rule: when the hold counter reaches HOLD_MAX-1 with no acceptance, the register clears and cmd_err pulses.
- Simultaneous events:
  - CKE falling while a column command is pending keeps it pending. Its strobe is still driven, and CKEL is asserted too.
  - cfg_req is forwarded as CFG, registered, independent of all other logic.
- Reset asserted mid-operation clears the pending command immediately, with no cmd_err.

## Timing
- Latency is 1: pins sampled at edge N produce a strobe that is valid from edge N through edge N+1.
- One-cycle strobes last exactly one cycle, even if identical pins repeat. Each sampled command is independent, so two consecutive REF samples produce two pulses.
- Column strobe: rises one cycle after sampling and stays high through the cycle in which stateout first shows the target state. It is low from the following edge.
- Hold counter is 8 bits and saturates. HOLD_MAX must be no more than 255.
- Timeout: the strobe is high for exactly HOLD_MAX cycles, and cmd_err pulses in the cycle after the last high cycle.
- CKEL follows cke_q, so it is delayed by one cycle.

## Test plan
- Idle case: with stateout=0x00, pins cs_n=0, act_n=0 -> ACT high for exactly 1 cycle, one cycle after sampling. The same pins with stateout=0x03 -> no ACT and a cmd_err pulse.
- Write-with-auto-precharge hold: stateout=0x03, RAS/CAS/WE=100, a10=1 -> WRA high. Hold stateout=0x03 for 5 cycles, then drive 0x13 -> WRA high for 6 cycles total then low, with no cmd_err.
- Power-down cycle:
  - CKE 1->0 with deselect -> PD pulse, lpmode=1, CKEL high.
  - Then a CKE 0->1 -> CKEH and PDX pulse together, and lpmode=0.
  - Repeat with 001 pins -> SRF, then exit produces CKEH only.
- Timeout: HOLD_MAX=4, issue RD in BankActive and hold stateout=0x03 -> RD high for 4 cycles, then cmd_err pulses for 1 cycle.
- Precharge variants: 010 with a10=0 -> PR; with a10=1 -> PRA. Both pulse for 1 cycle in any state. A PR sampled while RD is pending leaves RD high.
- Reset mid-hold: assert rst low asynchronously while WR is pending -> WR, CKEH, and cmd_err are 0 immediately. After release, a command on the same edge as release has no effect.
